// File: rtl/video_fill_controller.sv
// Rectangle-fill engine sharing the framebuffer port with the core.
// Software programs ORIGIN/SIZE/COLOUR, then writes CTRL.start. The engine
// writes one byte per free cycle in raster order. Core framebuffer accesses
// always take the port and the engine holds its position while they do.
//
// Handshake: there is no back-pressure from framebuffer_interface. An fb_*
// strobe is a complete transfer in the cycle it is high. The only flow control
// is the core-wins stall: a cycle with a core framebuffer access is a cycle in
// which the engine presents nothing and advances nothing.
module video_fill_controller #(
    parameter int          SCREEN_WIDTH  = 320,
    parameter int          SCREEN_HEIGHT = 240,
    parameter logic [31:0] FB0_BASE      = 32'hFF00_0000,
    parameter logic [31:0] FB1_BASE      = 32'hFF10_0000,
    parameter logic [31:0] REG_BASE      = 32'hFF20_0600
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        frame_start,
    input  logic [31:0] bus_address,
    input  logic [31:0] bus_write_data,
    input  logic [2:0]  bus_format,
    input  logic        bus_read_enable,
    input  logic        bus_write_enable,
    output logic [31:0] bus_data_fetched,
    output logic [31:0] fb_address,
    output logic [31:0] fb_write_data,
    output logic [2:0]  fb_format,
    output logic        fb_read_enable,
    output logic        fb_write_enable,
    output logic        fill_busy,
    output logic        fill_done
);

    localparam logic [31:0] FRAME_BYTES = 32'(SCREEN_WIDTH * SCREEN_HEIGHT);
    localparam logic [10:0] SW11        = 11'(SCREEN_WIDTH);
    localparam logic [10:0] SH11        = 11'(SCREEN_HEIGHT);
    localparam logic [31:0] ROW_STRIDE  = 32'(SCREEN_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WAIT_VS = 3'd1,
        S_SETUP   = 3'd2,
        S_FILL    = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t state;
    state_t state_next;

    // Programmed registers (software view).
    logic [9:0] org_x_q, org_y_q;
    logic [9:0] size_w_q, size_h_q;
    logic [7:0] colour_q;
    logic       frame_q;

    // Status flags.
    logic done_q;
    logic error_q;

    // Parameters latched in SETUP and the running pixel position.
    logic [9:0]  x_start_q;
    logic [9:0]  x_end_q;
    logic [9:0]  y_end_q;
    logic [9:0]  cx_q;
    logic [9:0]  cy_q;
    logic [31:0] row_addr_q;
    logic [7:0]  fill_colour_q;

    // Bus decode.
    logic       reg_hit;
    logic [1:0] reg_sel;
    logic       reg_wr;
    logic       ctrl_wr;
    logic       start_cmd;
    logic       abort_cmd;
    logic       vsync_cmd;
    logic       start_accept;
    logic       in_fb0;
    logic       in_fb1;
    logic       core_access;

    // SETUP-time derived values.
    logic [10:0] x_sum;
    logic [10:0] y_sum;
    logic [10:0] x_lim;
    logic [10:0] y_lim;
    logic [10:0] x_end_calc;
    logic [10:0] y_end_calc;
    logic        setup_bad;
    logic [31:0] row_base;

    logic        last_px;
    logic [9:0]  col_off;
    logic        unused_bits;

    assign unused_bits = ^{bus_write_data[31:26], bus_write_data[15:10], bus_address[1:0],
                           x_end_calc[10], y_end_calc[10]};

    // Address decode and CTRL command strobes.
    always_comb begin
        reg_hit      = (bus_address[31:4] == REG_BASE[31:4]);
        reg_sel      = bus_address[3:2];
        reg_wr       = bus_write_enable && reg_hit;
        ctrl_wr      = reg_wr && (reg_sel == 2'd3);
        start_cmd    = ctrl_wr && bus_write_data[0];
        abort_cmd    = ctrl_wr && bus_write_data[1];
        vsync_cmd    = bus_write_data[2];
        start_accept = (state == S_IDLE) && start_cmd && !abort_cmd;
        in_fb0       = (bus_address >= FB0_BASE) && (bus_address < FB0_BASE + FRAME_BYTES);
        in_fb1       = (bus_address >= FB1_BASE) && (bus_address < FB1_BASE + FRAME_BYTES);
        // Reset forces the port quiet, including core traffic.
        core_access  = reset && (bus_read_enable || bus_write_enable) && (in_fb0 || in_fb1);
    end

    // Clip and validate the programmed rectangle; sums are 11 bits so they cannot wrap.
    always_comb begin
        x_sum      = {1'b0, org_x_q} + {1'b0, size_w_q};
        y_sum      = {1'b0, org_y_q} + {1'b0, size_h_q};
        x_lim      = (x_sum > SW11) ? SW11 : x_sum;
        y_lim      = (y_sum > SH11) ? SH11 : y_sum;
        x_end_calc = x_lim - 11'd1;
        y_end_calc = y_lim - 11'd1;
        setup_bad  = (size_w_q == 10'd0) || (size_h_q == 10'd0) ||
                     ({1'b0, org_x_q} >= SW11) || ({1'b0, org_y_q} >= SH11);
        row_base   = (frame_q ? FB1_BASE : FB0_BASE) +
                     (32'(org_y_q) * ROW_STRIDE) + 32'(org_x_q);
    end

    // Software-visible configuration registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            org_x_q  <= '0;
            org_y_q  <= '0;
            size_w_q <= '0;
            size_h_q <= '0;
            colour_q <= '0;
            frame_q  <= 1'b0;
        end else if (reg_wr) begin
            case (reg_sel)
                2'd0: begin
                    org_x_q <= bus_write_data[9:0];
                    org_y_q <= bus_write_data[25:16];
                end
                2'd1: begin
                    size_w_q <= bus_write_data[9:0];
                    size_h_q <= bus_write_data[25:16];
                end
                2'd2: begin
                    colour_q <= bus_write_data[7:0];
                    frame_q  <= bus_write_data[8];
                end
                default: ;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state: abort from any busy state overrides normal progress.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start_accept) begin
                    state_next = vsync_cmd ? S_WAIT_VS : S_SETUP;
                end
            end
            S_WAIT_VS: begin
                if (frame_start) begin
                    state_next = S_SETUP;
                end
            end
            S_SETUP: begin
                state_next = setup_bad ? S_IDLE : S_FILL;
            end
            S_FILL: begin
                if (!core_access && last_px) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
        if (abort_cmd && (state != S_IDLE)) begin
            state_next = S_IDLE;
        end
    end

    assign last_px = (cx_q == x_end_q) && (cy_q == y_end_q);
    assign col_off = cx_q - x_start_q;

    // Fill datapath: latch in SETUP, step the raster position on free FILL cycles.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            x_start_q     <= '0;
            x_end_q       <= '0;
            y_end_q       <= '0;
            cx_q          <= '0;
            cy_q          <= '0;
            row_addr_q    <= '0;
            fill_colour_q <= '0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_accept) begin
                        done_q  <= 1'b0;
                        error_q <= 1'b0;
                    end
                end
                S_SETUP: begin
                    x_start_q     <= org_x_q;
                    x_end_q       <= x_end_calc[9:0];
                    y_end_q       <= y_end_calc[9:0];
                    cx_q          <= org_x_q;
                    cy_q          <= org_y_q;
                    row_addr_q    <= row_base;
                    fill_colour_q <= colour_q;
                    if (setup_bad && !abort_cmd) begin
                        error_q <= 1'b1;
                    end
                end
                S_FILL: begin
                    if (!core_access) begin
                        if (cx_q == x_end_q) begin
                            cx_q       <= x_start_q;
                            cy_q       <= cy_q + 10'd1;
                            row_addr_q <= row_addr_q + ROW_STRIDE;
                        end else begin
                            cx_q <= cx_q + 10'd1;
                        end
                    end
                end
                S_DONE: begin
                    if (!abort_cmd) begin
                        done_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Port mux: core traffic passes straight through, otherwise the engine byte write.
    always_comb begin
        fb_address      = '0;
        fb_write_data   = '0;
        fb_format       = '0;
        fb_read_enable  = 1'b0;
        fb_write_enable = 1'b0;
        if (core_access) begin
            fb_address      = bus_address;
            fb_write_data   = bus_write_data;
            fb_format       = bus_format;
            fb_read_enable  = bus_read_enable;
            fb_write_enable = bus_write_enable;
        end else if (state == S_FILL) begin
            fb_address      = row_addr_q + 32'(col_off);
            fb_write_data   = {4{fill_colour_q}};
            fb_format       = 3'b000;
            fb_write_enable = 1'b1;
        end
    end

    // Combinational register read-back.
    always_comb begin
        bus_data_fetched = '0;
        if (reg_hit) begin
            case (reg_sel)
                2'd0: bus_data_fetched = {6'd0, org_y_q, 6'd0, org_x_q};
                2'd1: bus_data_fetched = {6'd0, size_h_q, 6'd0, size_w_q};
                2'd2: bus_data_fetched = {23'd0, frame_q, colour_q};
                default: bus_data_fetched = {29'd0, error_q, done_q, fill_busy};
            endcase
        end
    end

    assign fill_busy = (state != S_IDLE);
    assign fill_done = done_q;

endmodule

// File: doc/video_fill_controller.md
Name: video_fill_controller

Overview:
- MMIO-programmed rectangle-fill engine. It writes a solid 8-bit colour into framebuffer 0 or 1.
- It shares the framebuffer bus port with the core: it sits between the core data bus and framebuffer_interface and muxes core accesses with its own generated byte writes.
- Core accesses always win. The engine stalls on any cycle the core uses the port.
- Software configures origin, size, colour and target frame, then starts the fill, optionally synchronised to start-of-frame.

Parameters:
- SCREEN_WIDTH, 320, pixels per row; also the row stride in bytes.
- SCREEN_HEIGHT, 240, rows per frame.
- FB0_BASE, 32'hFF00_0000, byte address of frame 0.
- FB1_BASE, 32'hFF10_0000, byte address of frame 1.
- REG_BASE, 32'hFF20_0600, base address of the 4 word registers.

Ports:
- clock  in  1  core clock; single clock domain.
- reset  in  1  asynchronous, active-low reset.
- frame_start  in  1  one-cycle pulse at start of vertical blank, already synchronised to clock.
- bus_address  in  32  core bus address.
- bus_write_data  in  32  core write data.
- bus_format  in  3  core access format.
- bus_read_enable  in  1  core read strobe.
- bus_write_enable  in  1  core write strobe.
- bus_data_fetched  out  32  register read data; 0 when the address is not a register.
- fb_address  out  32  address to framebuffer_interface.
- fb_write_data  out  32  write data to framebuffer_interface.
- fb_format  out  3  access format to framebuffer_interface.
- fb_read_enable  out  1  read strobe to framebuffer_interface.
- fb_write_enable  out  1  write strobe to framebuffer_interface.
- fill_busy  out  1  engine is not IDLE.
- fill_done  out  1  sticky completion flag.

Behaviour:
- Registers (word offsets from REG_BASE):
  - 0x0 ORIGIN: x[9:0], y[25:16].
  - 0x4 SIZE: w[9:0], h[25:16].
  - 0x8 COLOUR: colour[7:0], frame[8].
  - 0xC CTRL/STATUS. Write: bit0 start, bit1 abort, bit2 wait_vsync. Read: bit0 busy, bit1 done, bit2 error.
- Register read is combinational.
- Writes to ORIGIN, SIZE and COLOUR are accepted at any time. Their values are latched only in SETUP, so writes while busy do not affect the running fill.
- Reset: all registers = 0, state = IDLE, every fb_* output = 0, fill_busy = 0, fill_done = 0, error = 0.
- Port mux:
  - Core access = a read or write enable with an address inside either framebuffer range. It is forwarded to the fb_* outputs unchanged in the same cycle.
  - Otherwise, in FILL, fb_* carries the engine write: fb_format = 3'b000 (byte), fb_write_data = {4{colour}}, fb_write_enable = 1.
- States: IDLE, WAIT_VS, SETUP, FILL, DONE.
- IDLE -> start=1:
  - Clears done and error.
  - Goes to WAIT_VS if wait_vsync = 1, else SETUP.
  - A start written while not IDLE is ignored.
- WAIT_VS -> SETUP on the first frame_start pulse.
- SETUP (1 cycle):
  - Latch the parameters.
  - If w = 0, h = 0, x >= SCREEN_WIDTH or y >= SCREEN_HEIGHT: set error and go to IDLE; no writes occur.
  - Otherwise clip: x_end = min(x+w, SCREEN_WIDTH) - 1 and y_end = min(y+h, SCREEN_HEIGHT) - 1, using 11-bit sums with no wrap.
  - row_addr = base + y*SCREEN_WIDTH + x.
- FILL:
  - One pixel per unstalled cycle, raster order.
  - Address = row_addr + (cx - x).
  - At cx = x_end: row_addr += SCREEN_WIDTH and cx = x.
  - A stalled cycle holds the pixel counters; no pixel is skipped or duplicated.
  - The last pixel is cx = x_end, cy = y_end; the next state is DONE.
- DONE (1 cycle): set done, go to IDLE.
- Unstalled latency from the start write: 1 (SETUP) + W*H write cycles + 1 (DONE). done is visible on the cycle after DONE.
- Abort (CTRL bit1) from any non-IDLE state goes to IDLE next cycle. done is not set, and pixels already written stay written. If start and abort are written together, abort wins.
- A core write to REG_BASE and a core framebuffer access cannot coincide, since they are on the same bus.
- An asynchronous reset mid-fill drops all fb_* outputs to 0 immediately.

Test Plan:
1. Reset asserted mid-FILL -> fb_write_enable = 0 and fill_busy = 0 immediately; STATUS reads 0 after release.
2. ORIGIN = (10,2), SIZE = (3,2), COLOUR = 0xAB, frame 0, start -> byte writes to 0xFF00028A, 0xFF00028B, 0xFF00028C, 0xFF0003CA, 0xFF0003CB, 0xFF0003CC with data 0xABABABAB. done is set 8 cycles after the start write.
3. ORIGIN = (318,239), SIZE = (5,4), frame 1 -> exactly 2 writes, to 0xFF112BFE and 0xFF112BFF, then done.
4. Core writes 0xFF000000 during the 3rd pixel of scenario 2 -> the core write appears on fb_* unchanged that cycle, the engine stalls one cycle, and all 6 pixels are still written exactly once.
5. SIZE w = 0 -> error = 1, done = 0, no fb writes. Separately, abort after 2 pixels -> busy drops next cycle, done = 0, and a new start is then accepted.
6. wait_vsync = 1 -> no writes until the frame_start pulse; the first write comes 2 cycles after it. A start written while busy -> ignored, and the pixel count is unchanged.
